gpu_clear_engine: RTL and testbench

Hardware fill engine for the character display. It sits between the GPU register block and the character buffer's CPU write port, in the CPU clock domain. It executes full-screen clear and single-line clear commands by writing a fill character into the buffer. It also passes ordinary CPU character writes through with fixed priority over its own writes, so software no longer has to loop over up to 2400 cells.

---
 rtl/gpu_clear_engine.sv | 155 +++++++++++++++
 tb/tb_gpu_clear_engine.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_clear_engine.sv
// gpu_clear_engine: hardware fill engine for the character display.
//
// Performs full-screen and single-line clears by writing FILL_CHAR into the
// character buffer. CPU writes pass through with priority over engine writes.
// A CPU write during FILL stalls the engine for that cycle.
//
// Build option: define GPU_CLEAR_LINE_EN to compile in line-clear support.
// With the macro undefined, line_clear_start and line_index are ignored.
module gpu_clear_engine #(
    parameter logic [7:0]  FILL_CHAR = 8'h20,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic              clk_cpu,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    input  logic              cpu_we,
    input  logic              mode_80col,
    input  logic              clear_start,
    input  logic              line_clear_start,
    input  logic [4:0]        line_index,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic              buf_we
);

    typedef enum logic {StIdle, StFill} state_e;

    localparam logic [ADDR_W-1:0] Stride40 = ADDR_W'(40);
    localparam logic [ADDR_W-1:0] Stride80 = ADDR_W'(80);
    localparam logic [ADDR_W-1:0] RowsA    = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] One      = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    // fin_q marks the cycle between the last engine write and the done pulse.
    logic              fin_q, fin_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              buf_we_q, buf_we_d;

    logic [ADDR_W-1:0] stride;
    logic [ADDR_W-1:0] full_last;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] line_last;
    logic              line_go;

    // Command geometry, evaluated from the mode at the start edge only.
    always_comb begin
        stride    = mode_80col ? Stride80 : Stride40;
        full_last = (RowsA * stride) - One;
        line_base = ADDR_W'(line_index) * stride;
        line_last = line_base + stride - One;
    end

`ifdef GPU_CLEAR_LINE_EN
    // Out-of-range rows are dropped here so they never reach the FSM.
    assign line_go = line_clear_start && (32'(line_index) < ROWS);
`else
    logic unused_line;
    assign unused_line = ^{line_clear_start, line_index};
    assign line_go     = 1'b0;
`endif

    // Next-state logic: CPU pass-through, command start/abort and fill stepping.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        fin_d      = 1'b0;
        done_d     = fin_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_we_d   = 1'b0;

        if (cpu_we) begin
            buf_we_d   = 1'b1;
            buf_addr_d = cpu_addr;
            buf_data_d = cpu_data;
        end

        unique case (state_q)
            StIdle: begin
                if (clear_start) begin
                    state_d = StFill;
                    ptr_d   = '0;
                    last_d  = full_last;
                end else if (line_go) begin
                    state_d = StFill;
                    ptr_d   = line_base;
                    last_d  = line_last;
                end
            end
            StFill: begin
                if (clear_start) begin
                    // Abort and restart; the aborted command never reports done.
                    ptr_d  = '0;
                    last_d = full_last;
                end else if (!cpu_we) begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = ptr_q;
                    buf_data_d = FILL_CHAR;
                    ptr_d      = ptr_q + One;
                    if (ptr_q == last_q) begin
                        state_d = StIdle;
                        fin_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StFill) || fin_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            last_q     <= '0;
            fin_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            fin_q      <= fin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_we_q   <= buf_we_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign buf_addr = buf_addr_q;
    assign buf_data = buf_data_q;
    assign buf_we   = buf_we_q;

endmodule

// File: tb/tb_gpu_clear_engine.sv
// Scoreboard bench for gpu_clear_engine. The reference model keeps a queue of
// addresses still to be filled; each edge either a CPU write or the next fill
// address is expected on the buffer port.
module tb_gpu_clear_engine;

    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int FILL   = 8'h20;
`ifdef GPU_CLEAR_LINE_EN
    localparam bit LINE_EN = 1'b1;
`else
    localparam bit LINE_EN = 1'b0;
`endif

    logic              clk_cpu = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [7:0]        cpu_data = '0;
    logic              cpu_we = 1'b0;
    logic              mode_80col = 1'b0;
    logic              clear_start = 1'b0;
    logic              line_clear_start = 1'b0;
    logic [4:0]        line_index = '0;
    logic              busy, done, buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;

    gpu_clear_engine dut (
        .clk_cpu          (clk_cpu),
        .rst_n            (rst_n),
        .cpu_addr         (cpu_addr),
        .cpu_data         (cpu_data),
        .cpu_we           (cpu_we),
        .mode_80col       (mode_80col),
        .clear_start      (clear_start),
        .line_clear_start (line_clear_start),
        .line_index       (line_index),
        .busy             (busy),
        .done             (done),
        .buf_addr         (buf_addr),
        .buf_data         (buf_data),
        .buf_we           (buf_we)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  fq[$];
    bit  fin = 1'b0;
    bit  exp_busy = 1'b0;
    int  last_a = 0;
    int  last_d = 0;
    int  edge_cnt = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk_cpu) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: compares every observed buffer cycle and done pulse with the scoreboard.
    always @(negedge clk_cpu) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            if (buf_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h at edge %0d",
                             buf_addr, buf_data, edge_cnt);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    if (buf_addr !== w.addr[ADDR_W-1:0] || buf_data !== w.data[7:0] ||
                        edge_cnt != w.cyc) begin
                        errors++;
                        $display("FAIL write: got addr %0d data %0h edge %0d, expected addr %0d data %0h edge %0d",
                                 buf_addr, buf_data, edge_cnt, w.addr, w.data, w.cyc);
                    end
                    last_a = w.addr;
                    last_d = w.data;
                end
            end else begin
                chk("buf_we", 32'(buf_we), 32'd0);
                chk("hold_addr", 32'(buf_addr), 32'(last_a));
                chk("hold_data", 32'(buf_data), 32'(last_d));
                if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_write: addr %0d expected at edge %0d, buf_we low",
                             w.addr, w.cyc);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: at edge %0d", edge_cnt);
                end else begin
                    int c;
                    c = done_q.pop_front();
                    if (c != edge_cnt) begin
                        errors++;
                        $display("FAIL done_cycle: got edge %0d expected edge %0d", edge_cnt, c);
                    end
                end
            end else if (done_q.size() > 0 && done_q[0] <= edge_cnt) begin
                int c;
                c = done_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_done: expected at edge %0d, done low", c);
            end
        end
    end

    // Drive one cycle of inputs and advance the model across the coming edge.
    task automatic step(input bit we, input int a, input int d, input bit clr, input bit lclr,
                        input int idx, input bit m80);
        int  e;
        int  stride;
        bit  idle;
        wr_t w;
        cpu_we           = we;
        cpu_addr         = a[ADDR_W-1:0];
        cpu_data         = d[7:0];
        clear_start      = clr;
        line_clear_start = lclr;
        line_index       = idx[4:0];
        mode_80col       = m80;
        e      = edge_cnt + 1;
        stride = m80 ? 80 : 40;
        if (fin) begin
            done_q.push_back(e);
            fin = 1'b0;
        end
        idle = (fq.size() == 0);
        if (clr) begin
            fq.delete();
            for (int i = 0; i < ROWS * stride; i++) fq.push_back(i);
        end else if (lclr && LINE_EN && idx < ROWS && idle) begin
            for (int i = 0; i < stride; i++) fq.push_back(idx * stride + i);
        end else if (!idle && !we) begin
            w.addr = fq.pop_front();
            w.data = FILL;
            w.cyc  = e;
            exp_q.push_back(w);
            if (fq.size() == 0) fin = 1'b1;
        end
        if (we) begin
            w.addr = a;
            w.data = d;
            w.cyc  = e;
            exp_q.push_back(w);
        end
        exp_busy = (fq.size() > 0) || fin;
        @(negedge clk_cpu);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, $urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (fq.size() > 0 || fin); i++) idle_steps(1);
        chk("wait_idle_timeout", 32'(fq.size() > 0 || fin), 32'd0);
        idle_steps(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_buf_we", 32'(buf_we), 32'd0);
        chk("rst_buf_addr", 32'(buf_addr), 32'd0);
        chk("rst_buf_data", 32'(buf_data), 32'd0);
        fq.delete();
        fin      = 1'b0;
        exp_busy = 1'b0;
        last_a   = 0;
        last_d   = 0;
        chk("rst_exp_q_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        done_q.delete();
        cpu_we           = 1'b0;
        clear_start      = 1'b0;
        line_clear_start = 1'b0;
        repeat (2) @(negedge clk_cpu);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk_cpu);
        #1;
        do_reset();

        // CPU pass-through
        step(1, 5, 8'h41, 0, 0, 0, 0);
        idle_steps(3);

        // Full clear, 80 columns
        step(0, 0, 0, 1, 0, 0, 1);
        wait_idle();

        // Line clears: valid row and out-of-range row
        step(0, 0, 0, 0, 1, 3, 0);
        wait_idle();
        step(0, 0, 0, 0, 1, 30, 0);
        idle_steps(5);
        step(0, 0, 0, 0, 1, 29, 1);
        wait_idle();

        // Full clear with three CPU stalls and a mode change mid-fill
        step(0, 0, 0, 1, 0, 0, 0);
        idle_steps(100);
        step(1, 700, 8'h55, 0, 0, 0, 1);
        idle_steps(50);
        step(1, 3, 8'hAA, 0, 0, 0, 1);
        step(1, 2399, 8'h7E, 0, 0, 0, 0);
        wait_idle();

        // Line clear aborted by full clear; ignored line clear while busy
        step(0, 0, 0, 0, 1, 5, 1);
        idle_steps(20);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 7, 0);
        wait_idle();

        // Simultaneous commands: full clear wins
        step(0, 0, 0, 1, 1, 2, 0);
        wait_idle();

        // Back-to-back: new command on the done edge
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 200 && !fin; i++) idle_steps(1);
        step(0, 0, 0, 0, 1, 2, 1);
        wait_idle();

        // Reset mid-clear
        step(0, 0, 0, 1, 0, 0, 1);
        idle_steps(300);
        do_reset();
        idle_steps(10);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, $urandom_range(0, 4095), $urandom_range(0, 255),
                 ($urandom % 250) == 0, ($urandom % 8) == 0, $urandom_range(0, 31),
                 $urandom_range(0, 1));
        end
        wait_idle();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
